mem_data_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port data RAM (11-bit word address, 32-bit data, registered read with 1-cycle rdy).
- Port A: core MEM stage. Port B: loader/debug master.
- Round-robin shares the RAM, sequences write or read/wait-for-rdy, and returns a one-cycle ack with read data.
- Sits between the MEM/WB stage and the data memory.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 25 ++
 rtl/mem_data_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the data-memory arbiter.
// Used by mem_data_arbiter and rr_arb2.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 11;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the port that was not
// served last wins.
module rr_arb2 (
    input  logic a_req,
    input  logic b_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);
    import mem_arb_pkg::*;

    // Grant selection from current requests and previous owner
    always_comb begin
        grant_valid = a_req | b_req;
        grant_owner = OWN_A;
        if (a_req && b_req) begin
            grant_owner = (last_owner == OWN_A) ? OWN_B : OWN_A;
        end else if (b_req) begin
            grant_owner = OWN_B;
        end else begin
            grant_owner = OWN_A;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data RAM.
// Optional access timeout enabled by defining MEM_DATA_ARB_TIMEOUT_EN.
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    state_t            state_r, state_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic              we_r, we_nxt_s;
    logic              last_owner_r, last_owner_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              mem_read_r, mem_read_nxt_s;
    logic              mem_write_r, mem_write_nxt_s;
    logic              a_ack_r, a_ack_nxt_s;
    logic              b_ack_r, b_ack_nxt_s;
    logic [DATA_W-1:0] a_rdata_r, a_rdata_nxt_s;
    logic [DATA_W-1:0] b_rdata_r, b_rdata_nxt_s;
    logic              err_r, err_nxt_s;
    logic              grant_valid_s, grant_owner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
`ifdef MEM_DATA_ARB_TIMEOUT_EN
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYC - 1);
    logic [3:0]        wait_cnt_r, wait_cnt_nxt_s;
`endif

    rr_arb2 u_rr_arb2 (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_owner  (last_owner_r),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // Request fields of the granted port
    always_comb begin
        if (grant_owner_s == OWN_B) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // Next-state and next-output logic; acks, err and RAM strobes default low
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        we_nxt_s         = we_r;
        last_owner_nxt_s = last_owner_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        mem_read_nxt_s   = 1'b0;
        mem_write_nxt_s  = 1'b0;
        a_ack_nxt_s      = 1'b0;
        b_ack_nxt_s      = 1'b0;
        a_rdata_nxt_s    = a_rdata_r;
        b_rdata_nxt_s    = b_rdata_r;
        err_nxt_s        = 1'b0;
`ifdef MEM_DATA_ARB_TIMEOUT_EN
        wait_cnt_nxt_s   = wait_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    owner_nxt_s     = grant_owner_s;
                    we_nxt_s        = sel_we_s;
                    mem_addr_nxt_s  = sel_addr_s;
                    mem_wdata_nxt_s = sel_wdata_s;
                    mem_read_nxt_s  = ~sel_we_s;
                    mem_write_nxt_s = sel_we_s;
                    state_nxt_s     = ST_ISSUE;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    a_ack_nxt_s = (owner_r == OWN_A);
                    b_ack_nxt_s = (owner_r == OWN_B);
                    state_nxt_s = ST_ACK;
                end else begin
`ifdef MEM_DATA_ARB_TIMEOUT_EN
                    wait_cnt_nxt_s = 4'd0;
`endif
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rdy) begin
                    a_ack_nxt_s = (owner_r == OWN_A);
                    b_ack_nxt_s = (owner_r == OWN_B);
                    if (owner_r == OWN_A) begin
                        a_rdata_nxt_s = mem_rdata;
                    end else begin
                        b_rdata_nxt_s = mem_rdata;
                    end
                    state_nxt_s = ST_ACK;
`ifdef MEM_DATA_ARB_TIMEOUT_EN
                end else if (wait_cnt_r == TMO_LAST) begin
                    // Give up: complete with err and a zeroed read word
                    a_ack_nxt_s = (owner_r == OWN_A);
                    b_ack_nxt_s = (owner_r == OWN_B);
                    err_nxt_s   = 1'b1;
                    if (owner_r == OWN_A) begin
                        a_rdata_nxt_s = {DATA_W{1'b0}};
                    end else begin
                        b_rdata_nxt_s = {DATA_W{1'b0}};
                    end
                    state_nxt_s = ST_ACK;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 4'd1;
                    state_nxt_s    = ST_WAIT;
                end
`else
                end else begin
                    state_nxt_s = ST_WAIT;
                end
`endif
            end
            ST_ACK: begin
                last_owner_nxt_s = owner_r;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Hold registers and registered outputs; B counts as last owner out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_r      <= OWN_A;
            we_r         <= 1'b0;
            last_owner_r <= OWN_B;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            a_ack_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            a_rdata_r    <= {DATA_W{1'b0}};
            b_rdata_r    <= {DATA_W{1'b0}};
            err_r        <= 1'b0;
        end else begin
            owner_r      <= owner_nxt_s;
            we_r         <= we_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            mem_read_r   <= mem_read_nxt_s;
            mem_write_r  <= mem_write_nxt_s;
            a_ack_r      <= a_ack_nxt_s;
            b_ack_r      <= b_ack_nxt_s;
            a_rdata_r    <= a_rdata_nxt_s;
            b_rdata_r    <= b_rdata_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

`ifdef MEM_DATA_ARB_TIMEOUT_EN
    // Cycles spent waiting for mem_rdy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end
`endif

    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign err       = err_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;

endmodule
